// File: rtl/minimig_ram_arbiter_if.sv
// minimig_ram_arbiter_if
//   Bus between the RAM slot arbiter and minimig_sram_bridge.
//   master : arbiter side, drives bank/address/data/strobes, reads data back.
//   slave  : bridge side.
//   ram_bank      8   bank select (0 keeps the bridge disabled)
//   ram_address   18  word address [18:1]
//   ram_data_out  16  write data towards the bridge
//   ram_rd/hwr/lwr 1  read, high-byte write, low-byte write strobes
//   ram_data_in   16  read data from the bridge
interface minimig_ram_arbiter_if;
  logic [7:0]  ram_bank;
  logic [18:1] ram_address;
  logic [15:0] ram_data_out;
  logic        ram_rd;
  logic        ram_hwr;
  logic        ram_lwr;
  logic [15:0] ram_data_in;

  modport master (
    output ram_bank, ram_address, ram_data_out, ram_rd, ram_hwr, ram_lwr,
    input  ram_data_in
  );

  modport slave (
    input  ram_bank, ram_address, ram_data_out, ram_rd, ram_hwr, ram_lwr,
    output ram_data_in
  );
endinterface

// File: rtl/minimig_ram_arbiter.sv
// minimig_ram_arbiter
//   Slot arbiter for the single chip/slow RAM port. One slot per bus cycle:
//   the winner is picked at the Q1 edge, holds the bus through Q2/Q3, read
//   data is captured and the ack pulsed at the Q3 edge, and the bus is
//   released at the Q0 edge.
//   Phase decode: Q0=!c1&!c3  Q1=c1&!c3  Q2=c1&c3  Q3=!c1&c3.
//   Priority: DMA > starved host > CPU > host.
//
// Ports
//   clk, _reset      28 MHz clock, synchronous active-low reset
//   c1, c3           bus phase clock enables
//   dma_*            DMA request (no ack), dma_dout read data
//   cpu_*            CPU level request, cpu_ack pulse, cpu_dout read data
//   host_*           host (OSD/loader) port, same shape as the CPU port
//   ram              bridge bus (minimig_ram_arbiter_if.master)
//   owner            slot owner: 0 none, 1 DMA, 2 CPU, 3 host
//
// Configuration
//   MINIMIG_RAM_HOST_PORT_EN  builds the host port and its starvation
//                             counter; without it HOST_MAXWAIT is unused.
module minimig_ram_arbiter #(
  parameter int HOST_MAXWAIT = 8
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        c1,
  input  logic        c3,
  input  logic        dma_req,
  input  logic [7:0]  dma_bank,
  input  logic [18:1] dma_addr,
  input  logic [15:0] dma_din,
  input  logic        dma_rd,
  input  logic        dma_hwr,
  input  logic        dma_lwr,
  output logic [15:0] dma_dout,
  input  logic        cpu_req,
  input  logic [7:0]  cpu_bank,
  input  logic [18:1] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic        cpu_rd,
  input  logic        cpu_hwr,
  input  logic        cpu_lwr,
  output logic        cpu_ack,
  output logic [15:0] cpu_dout,
`ifdef MINIMIG_RAM_HOST_PORT_EN
  input  logic        host_req,
  input  logic [7:0]  host_bank,
  input  logic [18:1] host_addr,
  input  logic [15:0] host_din,
  input  logic        host_rd,
  input  logic        host_hwr,
  input  logic        host_lwr,
  output logic        host_ack,
  output logic [15:0] host_dout,
`endif
  minimig_ram_arbiter_if.master ram,
  output logic [1:0]  owner
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DMA  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_HOST = 2'd3;

  if (HOST_MAXWAIT < 1 || HOST_MAXWAIT > 15) begin : g_bad_maxwait
    $error("minimig_ram_arbiter: HOST_MAXWAIT must be 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACCESS, S_DONE} state_t;
  state_t state;

  logic q1_edge, q2_edge, q3_edge;
  assign q1_edge =  c1 && !c3;
  assign q2_edge =  c1 &&  c3;
  assign q3_edge = !c1 &&  c3;

`ifdef MINIMIG_RAM_HOST_PORT_EN
  localparam logic [3:0] MAXWAIT = 4'(HOST_MAXWAIT);
  logic [3:0] host_wait;
  logic       host_starved;
  assign host_starved = host_req && (host_wait >= MAXWAIT);
`endif

  // Winner of the upcoming Q1 edge and its access fields.
  logic [1:0]  win;
  logic [7:0]  sel_bank;
  logic [18:1] sel_addr;
  logic [15:0] sel_din;
  logic        sel_rd, sel_hwr, sel_lwr;

  always_comb begin
    win = OWN_NONE;
    if (dma_req)           win = OWN_DMA;
`ifdef MINIMIG_RAM_HOST_PORT_EN
    else if (host_starved) win = OWN_HOST;
`endif
    else if (cpu_req)      win = OWN_CPU;
`ifdef MINIMIG_RAM_HOST_PORT_EN
    else if (host_req)     win = OWN_HOST;
`endif
  end

  always_comb begin
    sel_bank = '0;
    sel_addr = '0;
    sel_din  = '0;
    sel_rd   = 1'b0;
    sel_hwr  = 1'b0;
    sel_lwr  = 1'b0;
    case (win)
      OWN_DMA: begin
        sel_bank = dma_bank; sel_addr = dma_addr; sel_din = dma_din;
        sel_rd = dma_rd; sel_hwr = dma_hwr; sel_lwr = dma_lwr;
      end
      OWN_CPU: begin
        sel_bank = cpu_bank; sel_addr = cpu_addr; sel_din = cpu_din;
        sel_rd = cpu_rd; sel_hwr = cpu_hwr; sel_lwr = cpu_lwr;
      end
`ifdef MINIMIG_RAM_HOST_PORT_EN
      OWN_HOST: begin
        sel_bank = host_bank; sel_addr = host_addr; sel_din = host_din;
        sel_rd = host_rd; sel_hwr = host_hwr; sel_lwr = host_lwr;
      end
`endif
      default: ;
    endcase
  end

  // Bank 0 leaves the bridge disabled, so its bus is meaningless: return 0.
  logic [15:0] rdata;
  assign rdata = (ram.ram_bank == 8'd0) ? 16'h0000 : ram.ram_data_in;

  logic in_slot;
  assign in_slot = (state == S_GRANT) || (state == S_ACCESS);

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state            <= S_IDLE;
      owner            <= OWN_NONE;
      ram.ram_bank     <= '0;
      ram.ram_address  <= '0;
      ram.ram_data_out <= '0;
      ram.ram_rd       <= 1'b0;
      ram.ram_hwr      <= 1'b0;
      ram.ram_lwr      <= 1'b0;
      dma_dout         <= '0;
      cpu_ack          <= 1'b0;
      cpu_dout         <= '0;
`ifdef MINIMIG_RAM_HOST_PORT_EN
      host_ack         <= 1'b0;
      host_dout        <= '0;
      host_wait        <= '0;
`endif
    end else begin
      cpu_ack <= 1'b0;
`ifdef MINIMIG_RAM_HOST_PORT_EN
      host_ack <= 1'b0;
`endif
      if (q1_edge) begin
        // sel_* are all zero when nobody wins, so the bus stays idle.
        state            <= (win != OWN_NONE) ? S_GRANT : S_IDLE;
        owner            <= win;
        ram.ram_bank     <= sel_bank;
        ram.ram_address  <= sel_addr;
        ram.ram_data_out <= sel_din;
        ram.ram_rd       <= sel_rd && !(sel_hwr || sel_lwr);  // write wins
        ram.ram_hwr      <= sel_hwr;
        ram.ram_lwr      <= sel_lwr;
`ifdef MINIMIG_RAM_HOST_PORT_EN
        // DMA slots are invisible to the host starvation count.
        if (!dma_req) begin
          if (win == OWN_HOST || !host_req)
            host_wait <= '0;
          else if (win == OWN_CPU && host_wait != 4'hF)
            host_wait <= host_wait + 4'd1;
        end
`endif
      end else if (q2_edge) begin
        if (state == S_GRANT) state <= S_ACCESS;
      end else if (q3_edge) begin
        // Entered from GRANT too, so a skipped Q2 still completes the slot.
        if (in_slot) begin
          state <= S_DONE;
          case (owner)
            OWN_DMA: if (ram.ram_rd) dma_dout <= rdata;
            OWN_CPU: begin
              cpu_ack <= 1'b1;
              if (ram.ram_rd) cpu_dout <= rdata;
            end
`ifdef MINIMIG_RAM_HOST_PORT_EN
            OWN_HOST: begin
              host_ack <= 1'b1;
              if (ram.ram_rd) host_dout <= rdata;
            end
`endif
            default: ;
          endcase
        end
      end else begin
        // Q0 edge: release the bus.
        state            <= S_IDLE;
        owner            <= OWN_NONE;
        ram.ram_bank     <= '0;
        ram.ram_address  <= '0;
        ram.ram_data_out <= '0;
        ram.ram_rd       <= 1'b0;
        ram.ram_hwr      <= 1'b0;
        ram.ram_lwr      <= 1'b0;
      end
    end
  end

endmodule

// File: doc/minimig_ram_arbiter.md
# minimig_ram_arbiter

Slot-based arbiter that shares the single chip/slow RAM port of the SRAM bridge between chipset DMA, the CPU and an optional host (OSD/loader) port. Once per 7.09 MHz bus cycle, defined by the `c1`/`c3` clock enables, it picks one requester, drives the bridge bus signals for exactly one bus cycle, captures read data and acknowledges the requester. It sits between the chipset/CPU glue and `minimig_sram_bridge`.

## Interface
- `HOST_MAXWAIT`, default 8: consecutive non-DMA slots the host may lose to the CPU before it is forced a slot. Range 1..15.
- `clk` in 1: 28 MHz system clock.
- `_reset` in 1: synchronous, active-low reset.
- `c1`, `c3` in 1 each: bus-phase clock enables. Q0 = !c1 & !c3, Q1 = c1 & !c3, Q2 = c1 & c3, Q3 = !c1 & c3.
- `dma_req` in 1: DMA owns this slot. Sampled at the Q1 edge. No ack.
- `dma_bank` in 8, `dma_addr` in 18 ([18:1]), `dma_din` in 16, `dma_rd`/`dma_hwr`/`dma_lwr` in 1: DMA access.
- `dma_dout` out 16: DMA read data.
- `cpu_req` in 1: level request, held until `cpu_ack`.
- `cpu_bank` 8, `cpu_addr` 18, `cpu_din` 16, `cpu_rd`/`cpu_hwr`/`cpu_lwr` 1, all inputs: CPU access.
- `cpu_ack` out 1: one-clk completion pulse.
- `cpu_dout` out 16: CPU read data, held until the next CPU completion.
- `host_req`, `host_bank`, `host_addr`, `host_din`, `host_rd`, `host_hwr`, `host_lwr` (in), `host_ack`, `host_dout` (out): same widths as the CPU port. Present only with `MINIMIG_RAM_HOST_PORT_EN`.
- `ram_bank` out 8, `ram_address` out 18, `ram_data_out` out 16, `ram_rd`/`ram_hwr`/`ram_lwr` out 1: drive the bridge inputs `bank`, `address_in`, `data_in`, `rd`, `hwr`, `lwr`.
- `ram_data_in` in 16: bridge `data_out`.
- `owner` out 2: current slot owner. 0 = none, 1 = DMA, 2 = CPU, 3 = host.

## Operation
- Slot FSM states:
  - IDLE: no access in progress.
  - GRANT: Q1 edge reached; owner and bus latched.
  - ACCESS: Q2 in progress.
  - DONE: Q3 edge reached; data latched and ack issued.
  - After DONE the FSM returns to IDLE at the following Q0 edge.
- Arbitration happens only on a rising `clk` with c1 & !c3 (the Q1 edge). Priority:
  1. `dma_req`.
  2. The host, if its starvation counter is at least `HOST_MAXWAIT`.
  3. `cpu_req`.
  4. `host_req`.
  5. Otherwise no owner.
- At GRANT, register the winner's bank, address, data and strobes onto the `ram_*` outputs. They hold constant through Q2 and Q3.
- Read/write conflict: if the winner asserts `rd` together with `hwr` or `lwr`, the write wins and `ram_rd` is 0.
- At the Q3 edge (!c1 & c3):
  - A read latches `ram_data_in` into the owner's `*_dout`.
  - The owner's ack pulses high for one clk. DMA has no ack.
- At the Q0 edge, all `ram_bank`/strobe outputs return to 0 and `owner` returns to 0.
- Host starvation counter (4 bits):
  - Increments, saturating at 15, at each Q1 edge where `host_req`=1 and the CPU wins.
  - Clears when the host is granted or `host_req`=0.
  - Is unchanged on DMA slots.
- A request with bank=0 is still granted. The bridge stays disabled, the slot consumes a cycle, the ack pulses, and read data returns 0.
- A requester that drops `req` after GRANT is not aborted: the slot completes and the ack still pulses.
- A request that rises between the Q1 edge and the next Q1 edge waits for the next Q1 edge.

## Timing
- Reset, synchronous with `_reset`=0 at any rising `clk`:
  - Next state: FSM IDLE, `ram_*`=0, `owner`=0, all acks 0, all `*_dout`=0, starvation counter 0.
  - Reset in mid-slot abandons the access with no ack.
- After `_reset` releases, the first grant can occur at the first Q1 edge.
- Grant-to-ack latency is 2 clk (Q1 edge to Q3 edge).
- Read data is valid in `*_dout` in the same clk as the ack.
- Back-to-back CPU accesses run one per bus cycle (4 clk) when there is no DMA.
- Any write-strobe assertion on `ram_*` aligns to the Q1..Q0 window, so the bridge sees a stable address across Q2.
- If `c1`/`c3` show an illegal sequence (a phase skipped), the FSM follows phase decoding only. No grant occurs without a Q1 edge.

## Configuration
- `MINIMIG_RAM_HOST_PORT_EN` defined:
  - The host port and its starvation counter are built.
  - `owner`=3 is reachable.
- `MINIMIG_RAM_HOST_PORT_EN` undefined:
  - The host ports are absent and the counter is removed.
  - Arbitration is DMA over CPU only.
  - `owner` never equals 3.
  - `HOST_MAXWAIT` is ignored.

## Test plan
- Reset: hold `_reset`=0 with `cpu_req`=1 across two bus cycles -> `owner`=0, `cpu_ack` never pulses, all `ram_*`=0. Release -> `cpu_ack` pulses 2 clk after the next Q1 edge.
- CPU read: `cpu_bank`=8'h01, `cpu_addr`=18'h00123, `cpu_rd`=1, bridge returns 16'hBEEF -> `ram_address`=18'h00123 from Q1 to Q0, `cpu_dout`=16'hBEEF with `cpu_ack` at the Q3 edge.
- DMA preemption: `dma_req` and `cpu_req` both set at the Q1 edge -> `owner`=1 and `cpu_ack` stays low. `dma_req` low in the next cycle -> CPU served then.
- Write/read conflict: CPU with `cpu_rd`=1, `cpu_hwr`=1, `cpu_lwr`=0, `cpu_din`=16'h1234 -> `ram_rd`=0, `ram_hwr`=1, `ram_data_out`=16'h1234.
- Host starvation (macro on, `HOST_MAXWAIT`=8): `cpu_req` and `host_req` held continuously, no DMA -> 8 CPU slots, then 1 host slot (`host_ack`), then CPU resumes.
- Bank 0: `cpu_bank`=0 with `cpu_rd`=1 -> `cpu_ack` pulses, `cpu_dout`=16'h0000.
